uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 140 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter, drained one byte at a time.
// Ports: i_clk/i_rst_n, push side (i_wr, i_data, i_flush, i_clr_ovf), status
// (o_full, o_empty, o_level, o_ovf), transmitter side (o_tx_wr, o_tx_data,
// i_tx_rdy, i_tx_bsy).
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr,
    input  logic [7:0]            i_data,
    input  logic                  i_flush,
    input  logic                  i_clr_ovf,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_ovf,
    output logic                  o_tx_wr,
    output logic [7:0]            o_tx_data,
    input  logic                  i_tx_rdy,
    input  logic                  i_tx_bsy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACC,
        WAIT_RDY
    } state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    state_t                state;
    state_t                state_nxt;
    logic                  push;
    logic                  pop;
    logic                  tx_wr_nxt;

    assign o_level = level;
    assign o_empty = (level == '0);
    assign o_full  = (level == LVL_FULL);

    // Full is the registered flag, so a push at full is dropped even when
    // the drain side pops in the same cycle.
    assign push = i_wr & ~o_full & ~i_flush;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_wr_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (!o_empty && i_tx_rdy) begin
                    pop       = 1'b1;
                    tx_wr_nxt = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_ACC;
            end
            WAIT_ACC: begin
                // Wait for the transmitter to show it took the byte.
                if (!i_tx_rdy || i_tx_bsy) begin
                    state_nxt = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (i_tx_rdy && !i_tx_bsy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            o_tx_wr   <= 1'b0;
            o_tx_data <= 8'h00;
        end else begin
            state   <= state_nxt;
            o_tx_wr <= tx_wr_nxt;
            if (pop) begin
                o_tx_data <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Set wins over clear so an overflow in the clearing cycle is not lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ovf <= 1'b0;
        end else if (i_wr && o_full) begin
            o_ovf <= 1'b1;
        end else if (i_clr_ovf) begin
            o_ovf <= 1'b0;
        end
    end

    // Storage has no reset; contents only matter while level is non-zero.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH_LOG2 = 4).
// Drives the transmitter handshake by hand and checks FIFO and drain behaviour.
module tb_uart_tx_fifo;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_wr = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_flush = 1'b0;
    logic       i_clr_ovf = 1'b0;
    logic       o_full;
    logic       o_empty;
    logic [4:0] o_level;
    logic       o_ovf;
    logic       o_tx_wr;
    logic [7:0] o_tx_data;
    logic       i_tx_rdy = 1'b0;
    logic       i_tx_bsy = 1'b0;

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr      (i_wr),
        .i_data    (i_data),
        .i_flush   (i_flush),
        .i_clr_ovf (i_clr_ovf),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_level   (o_level),
        .o_ovf     (o_ovf),
        .o_tx_wr   (o_tx_wr),
        .o_tx_data (o_tx_data),
        .i_tx_rdy  (i_tx_rdy),
        .i_tx_bsy  (i_tx_bsy)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_tx_wr === 1'b1) begin
            pulses++;
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for one write pulse, then acts as an accepting
    // transmitter: rdy low / bsy high for two cycles, then ready again.
    task automatic drain_one(output logic [7:0] d, output bit ok);
        ok = 1'b0;
        d = 8'h00;
        i_tx_rdy = 1'b1;
        i_tx_bsy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (o_tx_wr === 1'b1) begin
                ok = 1'b1;
                d = o_tx_data;
                break;
            end
        end
        i_tx_rdy = 1'b0;
        i_tx_bsy = 1'b1;
        cyc();
        cyc();
        i_tx_bsy = 1'b0;
        i_tx_rdy = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit         ok;
        int         p0;
        int         p1;

        // Reset values
        cyc();
        cyc();
        chk("rst_tx_wr", 32'(o_tx_wr), 32'd0);
        chk("rst_tx_data", 32'(o_tx_data), 32'h00);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_ovf", 32'(o_ovf), 32'd0);
        i_rst_n = 1'b1;
        i_tx_rdy = 1'b1;
        cyc();

        // Single byte, one-cycle latency
        i_wr = 1'b1;
        i_data = 8'h55;
        cyc();
        i_wr = 1'b0;
        chk("single_level1", 32'(o_level), 32'd1);
        chk("single_nowr_yet", 32'(o_tx_wr), 32'd0);
        cyc();
        chk("single_wr", 32'(o_tx_wr), 32'd1);
        chk("single_data", 32'(o_tx_data), 32'h55);
        chk("single_empty", 32'(o_empty), 32'd1);
        cyc();
        chk("single_wr_low", 32'(o_tx_wr), 32'd0);
        i_tx_rdy = 1'b0;
        i_tx_bsy = 1'b1;
        cyc();
        cyc();
        i_tx_rdy = 1'b1;
        i_tx_bsy = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("single_pulses", 32'(pulses), 32'd1);
        chk("single_hold", 32'(o_tx_data), 32'h55);

        // Ordering with transmitter not ready
        p0 = pulses;
        i_tx_rdy = 1'b0;
        i_wr = 1'b1;
        i_data = 8'h55;
        cyc();
        i_data = 8'hAA;
        cyc();
        i_data = 8'hC8;
        cyc();
        i_wr = 1'b0;
        chk("order_level3", 32'(o_level), 32'd3);
        cyc();
        cyc();
        chk("order_no_pulse", 32'(pulses), 32'(p0));
        drain_one(d, ok);
        chk("order_to0", 32'(ok), 32'd1);
        chk("order_b0", 32'(d), 32'h55);
        drain_one(d, ok);
        chk("order_to1", 32'(ok), 32'd1);
        chk("order_b1", 32'(d), 32'hAA);
        drain_one(d, ok);
        chk("order_to2", 32'(ok), 32'd1);
        chk("order_b2", 32'(d), 32'hC8);
        cyc();
        cyc();
        chk("order_pulses", 32'(pulses), 32'(p0 + 3));
        chk("order_empty", 32'(o_empty), 32'd1);

        // Full and overflow
        p0 = pulses;
        i_tx_rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            i_wr = 1'b1;
            i_data = 8'(8'h10 + i);
            cyc();
        end
        i_wr = 1'b0;
        chk("full_flag", 32'(o_full), 32'd1);
        chk("full_level", 32'(o_level), 32'd16);
        chk("full_ovf0", 32'(o_ovf), 32'd0);
        i_wr = 1'b1;
        i_data = 8'hEE;
        cyc();
        i_wr = 1'b0;
        chk("ovf_set", 32'(o_ovf), 32'd1);
        chk("ovf_level", 32'(o_level), 32'd16);
        i_wr = 1'b1;
        i_clr_ovf = 1'b1;
        cyc();
        i_wr = 1'b0;
        chk("ovf_set_clr", 32'(o_ovf), 32'd1);
        cyc();
        i_clr_ovf = 1'b0;
        chk("ovf_clr", 32'(o_ovf), 32'd0);
        for (int i = 0; i < 16; i++) begin
            drain_one(d, ok);
            chk("full_drain_to", 32'(ok), 32'd1);
            chk("full_drain", 32'(d), 32'(8'(8'h10 + i)));
        end
        cyc();
        cyc();
        cyc();
        cyc();
        chk("full_no17", 32'(pulses), 32'(p0 + 16));
        chk("full_empty", 32'(o_empty), 32'd1);

        // Wrap-around: 40 incrementing bytes in rounds of 10
        p0 = pulses;
        for (int r = 0; r < 4; r++) begin
            i_tx_rdy = 1'b0;
            for (int i = 0; i < 10; i++) begin
                i_wr = 1'b1;
                i_data = 8'(r * 10 + i);
                cyc();
            end
            i_wr = 1'b0;
            for (int i = 0; i < 10; i++) begin
                drain_one(d, ok);
                chk("wrap_to", 32'(ok), 32'd1);
                chk("wrap_byte", 32'(d), 32'(8'(r * 10 + i)));
            end
        end
        cyc();
        cyc();
        chk("wrap_pulses", 32'(pulses), 32'(p0 + 40));

        // Simultaneous push/pop at level 5, then flush in WAIT_RDY
        i_tx_rdy = 1'b1;
        i_tx_bsy = 1'b0;
        cyc();
        cyc();
        i_tx_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_wr = 1'b1;
            i_data = 8'(8'h61 + i);
            cyc();
        end
        i_wr = 1'b0;
        chk("sim_level5", 32'(o_level), 32'd5);
        i_wr = 1'b1;
        i_data = 8'h77;
        i_tx_rdy = 1'b1;
        cyc();
        i_wr = 1'b0;
        i_tx_rdy = 1'b0;
        i_tx_bsy = 1'b1;
        chk("sim_level_keep", 32'(o_level), 32'd5);
        chk("sim_wr", 32'(o_tx_wr), 32'd1);
        chk("sim_data", 32'(o_tx_data), 32'h61);
        cyc();
        cyc();
        p1 = pulses;
        i_flush = 1'b1;
        i_wr = 1'b1;
        i_data = 8'h99;
        cyc();
        i_flush = 1'b0;
        i_wr = 1'b0;
        chk("flush_level", 32'(o_level), 32'd0);
        chk("flush_empty", 32'(o_empty), 32'd1);
        i_tx_bsy = 1'b0;
        i_tx_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
        end
        chk("flush_no_reissue", 32'(pulses), 32'(p1));
        chk("flush_data_hold", 32'(o_tx_data), 32'h61);
        chk("flush_ovf", 32'(o_ovf), 32'd0);

        // Reset mid-drain with level 4 in WAIT_ACC
        i_tx_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_wr = 1'b1;
            i_data = 8'(8'h81 + i);
            cyc();
        end
        i_wr = 1'b0;
        i_tx_rdy = 1'b1;
        cyc();
        chk("mid_wr", 32'(o_tx_wr), 32'd1);
        chk("mid_level4", 32'(o_level), 32'd4);
        cyc();
        cyc();
        chk("mid_wait_acc_wr", 32'(o_tx_wr), 32'd0);
        chk("mid_wait_acc_lvl", 32'(o_level), 32'd4);
        chk("mid_data", 32'(o_tx_data), 32'h81);
        p1 = pulses;
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("async_tx_wr", 32'(o_tx_wr), 32'd0);
        chk("async_tx_data", 32'(o_tx_data), 32'h00);
        chk("async_level", 32'(o_level), 32'd0);
        chk("async_empty", 32'(o_empty), 32'd1);
        chk("async_full", 32'(o_full), 32'd0);
        chk("async_ovf", 32'(o_ovf), 32'd0);
        cyc();
        cyc();
        i_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
        end
        chk("post_rst_no_wr", 32'(pulses), 32'(p1));
        chk("post_rst_empty", 32'(o_empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
